// File: rtl/mvu_pe_acc.sv
// Fold accumulator for a matrix-vector PE: sums SF adder-tree beats per output
// and queues each finished sum in a 2-entry result FIFO.
module mvu_pe_acc #(
  parameter int TDstI = 16,
  parameter int TDstO = 24,
  parameter int SF    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TDstI-1:0] in_add,
  input  logic             in_add_v,
  output logic             in_add_rdy,
  output logic [TDstO-1:0] out_acc,
  output logic             out_acc_v,
  input  logic             out_acc_rdy
);

  localparam int CW = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CW-1:0] LAST = CW'(SF - 1);

  logic [CW-1:0]    sf_cnt_q, sf_cnt_d;
  logic [TDstO-1:0] acc_q, acc_d;
  logic [TDstO-1:0] mem_q [2];
  logic [TDstO-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             rdy_en_q;

  logic signed [TDstI-1:0] in_s;
  logic [TDstO-1:0]        ext_s;
  logic [TDstO-1:0]        sum_s;
  logic                    in_fire_s;
  logic                    push_s;
  logic                    pop_s;

  assign in_s       = in_add;
  assign ext_s      = TDstO'(in_s);
  // ready is held low through reset and only depends on registered occupancy
  assign in_add_rdy = rdy_en_q & (cnt_q != 2'd2);
  assign out_acc_v  = (cnt_q != 2'd0);
  assign out_acc    = mem_q[rd_ptr_q];
  assign in_fire_s  = in_add_v & in_add_rdy;
  assign push_s     = in_fire_s & (sf_cnt_q == LAST);
  assign pop_s      = out_acc_v & out_acc_rdy;
  assign sum_s      = (sf_cnt_q == '0) ? ext_s : (acc_q + ext_s);

  // next-state for fold counter, accumulator and FIFO
  always_comb begin
    sf_cnt_d = sf_cnt_q;
    acc_d    = acc_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (in_fire_s) begin
      acc_d = sum_s;
      if (sf_cnt_q == LAST) begin
        sf_cnt_d = '0;
      end else begin
        sf_cnt_d = sf_cnt_q + CW'(1);
      end
    end else begin
      acc_d = acc_q;
    end

    if (push_s) begin
      mem_d[wr_ptr_q] = sum_s;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sf_cnt_q <= '0;
      acc_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      rdy_en_q <= 1'b0;
    end else begin
      sf_cnt_q <= sf_cnt_d;
      acc_q    <= acc_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Directed bench for mvu_pe_acc: SF=4 main instance, SF=260 wrap instance,
// SF=1 instance for valid gaps. Inputs change on negedge, outputs checked there.
module tb_mvu_pe_acc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] in4, inw, in1;
  logic        v4, vw, v1;
  logic        irdy4, irdyw, irdy1;
  logic [23:0] out4, outw, out1;
  logic        ov4, ovw, ov1;
  logic        ordy4, ordyw, ordy1;

  int checks = 0;
  int fails  = 0;

  mvu_pe_acc #(.TDstI(16), .TDstO(24), .SF(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_add(in4), .in_add_v(v4), .in_add_rdy(irdy4),
    .out_acc(out4), .out_acc_v(ov4), .out_acc_rdy(ordy4));

  mvu_pe_acc #(.TDstI(16), .TDstO(24), .SF(260)) dutw (
    .clk(clk), .rst_n(rst_n), .in_add(inw), .in_add_v(vw), .in_add_rdy(irdyw),
    .out_acc(outw), .out_acc_v(ovw), .out_acc_rdy(ordyw));

  mvu_pe_acc #(.TDstI(16), .TDstO(24), .SF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_add(in1), .in_add_v(v1), .in_add_rdy(irdy1),
    .out_acc(out1), .out_acc_v(ov1), .out_acc_rdy(ordy1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] vals [8];
    logic [23:0] exps [8];
    int got;
    int acc_n;
    int idx;

    vals = '{16'h0005, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234, 16'hFF00, 16'h0001, 16'h0000};
    exps = '{24'h000005, 24'hFFFFFF, 24'hFF8000, 24'h007FFF, 24'h001234, 24'hFFFF00, 24'h000001, 24'h000000};

    rst_n = 1'b0;
    in4 = 16'd0; inw = 16'd0; in1 = 16'd0;
    v4 = 1'b0; vw = 1'b0; v1 = 1'b0;
    ordy4 = 1'b0; ordyw = 1'b0; ordy1 = 1'b0;

    // reset state
    #2;
    check("rst_irdy", irdy4, 1'b0);
    check("rst_ov", ov4, 1'b0);
    check("rst_out", out4, 24'd0);
    @(negedge clk);
    check("rst_irdy_clk", irdy4, 1'b0);
    rst_n = 1'b1;
    step();
    check("post_rst_irdy", irdy4, 1'b1);
    check("post_rst_ov", ov4, 1'b0);

    // basic fold 1+2+3+4
    ordy4 = 1'b1;
    v4 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in4 = 16'(i);
      step();
      check("fold_ov_early", ov4, 1'b0);
    end
    in4 = 16'd4;
    step();
    check("fold_ov", ov4, 1'b1);
    check("fold_out", out4, 24'd10);
    v4 = 1'b0;
    step();
    check("fold_ov_once", ov4, 1'b0);

    // sign extension: 4 x -32768
    v4 = 1'b1;
    in4 = 16'h8000;
    for (int i = 0; i < 4; i++) step();
    check("neg_ov", ov4, 1'b1);
    check("neg_out", out4, 24'hFE0000);
    v4 = 1'b0;
    step();

    // backpressure: three folds of ones with downstream stalled
    ordy4 = 1'b0;
    v4 = 1'b1;
    in4 = 16'd1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 3) begin
        check("bp_first_ov", ov4, 1'b1);
        check("bp_first_out", out4, 24'd4);
        check("bp_irdy_occ1", irdy4, 1'b1);
      end
    end
    check("bp_irdy_full", irdy4, 1'b0);
    check("bp_out_full", out4, 24'd4);
    for (int i = 0; i < 2; i++) begin
      step();
      check("bp_stall_irdy", irdy4, 1'b0);
      check("bp_stall_out", out4, 24'd4);
    end
    ordy4 = 1'b1;
    got = 0;
    acc_n = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      v4 = (acc_n < 4);
      if (ov4 && ordy4) begin
        check("bp_drain_out", out4, 24'd4);
        got++;
      end
      if (v4 && irdy4) acc_n++;
      step();
    end
    check("bp_drain_count", got, 3);
    check("bp_beats_taken", acc_n, 4);
    v4 = 1'b0;
    check("bp_empty_ov", ov4, 1'b0);
    check("bp_empty_irdy", irdy4, 1'b1);

    // simultaneous push and pop at occupancy 1
    ordy4 = 1'b0;
    v4 = 1'b1;
    in4 = 16'd1; step(); step(); step();
    in4 = 16'd2; step();
    check("pp_first_out", out4, 24'd5);
    check("pp_first_ov", ov4, 1'b1);
    in4 = 16'd2; step(); step(); step();
    check("pp_hold_out", out4, 24'd5);
    in4 = 16'd3;
    ordy4 = 1'b1;
    step();
    check("pp_out", out4, 24'd9);
    check("pp_ov", ov4, 1'b1);
    check("pp_irdy", irdy4, 1'b1);
    v4 = 1'b0;
    ordy4 = 1'b0;
    step();
    check("pp_stable_out", out4, 24'd9);
    check("pp_stable_ov", ov4, 1'b1);
    ordy4 = 1'b1;
    step();
    check("pp_drained", ov4, 1'b0);

    // reset mid-fold with a result pending
    ordy4 = 1'b0;
    v4 = 1'b1;
    in4 = 16'd3;
    for (int i = 0; i < 4; i++) step();
    in4 = 16'd5; step(); step();
    v4 = 1'b0;
    check("mr_pending_ov", ov4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_async_ov", ov4, 1'b0);
    check("mr_async_irdy", irdy4, 1'b0);
    check("mr_async_out", out4, 24'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mr_irdy", irdy4, 1'b1);
    ordy4 = 1'b1;
    v4 = 1'b1;
    in4 = 16'd1;
    for (int i = 0; i < 4; i++) step();
    check("mr_ov", ov4, 1'b1);
    check("mr_out", out4, 24'd4);
    v4 = 1'b0;
    step();

    // wrap past +2^23 with 260 beats of 0x7FFF
    ordyw = 1'b1;
    vw = 1'b1;
    inw = 16'h7FFF;
    for (int i = 0; i < 259; i++) step();
    check("wrap_ov_early", ovw, 1'b0);
    step();
    check("wrap_ov", ovw, 1'b1);
    check("wrap_out", outw, 24'h81FEFC);
    vw = 1'b0;
    step();
    check("wrap_ov_once", ovw, 1'b0);

    // SF=1 with valid gaps
    ordy1 = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
      v1 = (cyc % 3 == 2) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      in1 = v1 ? vals[idx] : 16'hDEAD;
      step();
      if (v1) begin
        check("sf1_ov", ov1, 1'b1);
        check("sf1_out", out1, exps[idx]);
        idx++;
      end else begin
        check("sf1_idle_ov", ov1, 1'b0);
      end
    end
    check("sf1_count", idx, 8);
    v1 = 1'b0;
    step();
    check("sf1_final_ov", ov1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mvu_pe_acc.md
MVU_PE_ACC -- requirements
Module: mvu_pe_acc

Interface
REQ-001 The block SHALL have parameter TDstI, default 16, meaning the word length of the adder-tree sum input.
REQ-002 The block SHALL have parameter TDstO, default 24, meaning the accumulator and output word length; it SHALL satisfy TDstO >= TDstI.
REQ-003 The block SHALL have parameter SF, default 4, meaning the synapse fold (adder-tree sums per output); it SHALL satisfy SF >= 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_add, input, TDstI bits: signed two's-complement adder-tree sum.
REQ-007 The block SHALL have port in_add_v, input, 1 bit: in_add is valid.
REQ-008 The block SHALL have port in_add_rdy, output, 1 bit: the block can accept in_add this cycle.
REQ-009 The block SHALL have port out_acc, output, TDstO bits: signed accumulated result.
REQ-010 The block SHALL have port out_acc_v, output, 1 bit: out_acc is valid.
REQ-011 The block SHALL have port out_acc_rdy, input, 1 bit: the downstream block accepts out_acc.

Function
REQ-012 An input beat SHALL be accepted in a cycle where in_add_v=1 and in_add_rdy=1 at the rising edge; an output beat SHALL be transferred where out_acc_v=1 and out_acc_rdy=1.
REQ-013 The block SHALL hold a fold counter sf_cnt in the range 0..SF-1 that increments on each accepted beat and wraps from SF-1 to 0.
REQ-014 On an accepted beat with sf_cnt=0, the accumulator SHALL load sign_extend(in_add) to TDstO bits; otherwise it SHALL load acc + sign_extend(in_add).
REQ-015 Addition SHALL be modulo 2^TDstO (wrap-around, no saturation, no overflow flag).
REQ-016 On an accepted beat with sf_cnt=SF-1, the completed sum (including that beat) SHALL be written into a 2-entry output FIFO in the same clock edge.
REQ-017 With SF=1, every accepted beat SHALL produce one result equal to sign_extend(in_add).
REQ-018 Latency SHALL be exactly 1 cycle: the result of the last beat of a fold appears on out_acc with out_acc_v=1 in the cycle after acceptance, provided the FIFO was empty.
REQ-019 The FIFO SHALL deliver results in fold order, and out_acc SHALL remain stable while out_acc_v=1 and out_acc_rdy=0.
REQ-020 in_add_rdy SHALL equal 1 whenever FIFO occupancy < 2, and SHALL equal 0 at occupancy 2, independent of out_acc_rdy (no combinational ready path).
REQ-021 A simultaneous push and pop SHALL leave occupancy unchanged and preserve ordering.
REQ-022 A pop from an empty FIFO and a push into a full FIFO SHALL never occur, and state SHALL NOT change on such an attempt.
REQ-023 Input beats that are not the last of a fold SHALL also be blocked while in_add_rdy=0.
REQ-024 Beats with in_add_v=0 SHALL NOT alter sf_cnt, the accumulator or the FIFO.

Reset
REQ-025 While rst_n=0, independent of clk, sf_cnt, the accumulator and FIFO occupancy SHALL clear to 0, out_acc SHALL be 0, out_acc_v SHALL be 0 and in_add_rdy SHALL be 0.
REQ-026 in_add_rdy SHALL go to 1 on the first rising clk edge after rst_n deasserts.
REQ-027 Reset asserted mid-fold SHALL discard the partial sum and all FIFO contents; the first beat accepted after reset SHALL start a new fold at sf_cnt=0.

Verification
REQ-028 The bench SHALL cover basic fold: SF=4, inputs 1,2,3,4 back-to-back, out_acc_rdy=1 -> out_acc=10 with out_acc_v=1 for exactly one cycle, one cycle after beat 4.
REQ-029 The bench SHALL cover sign and wrap: TDstI=16, TDstO=24, inputs 0x8000 x4 -> out_acc=0xFE0000 (-131072); inputs summing past +2^23 -> result wrapped modulo 2^24.
REQ-030 The bench SHALL cover backpressure: out_acc_rdy=0 for 3 folds of {1,1,1,1} -> two results (4,4) held in the FIFO, in_add_rdy=0 after the 2nd fold completes, the 9th beat stalls until out_acc_rdy=1, then three outputs of 4 appear in order.
REQ-031 The bench SHALL cover a simultaneous push and pop at occupancy 1 -> occupancy stays 1, order preserved, no lost or duplicated result.
REQ-032 The bench SHALL cover reset mid-fold: after beats 5,5, assert rst_n=0 asynchronously -> out_acc_v=0 immediately; after release, folds {1,1,1,1} -> out_acc=4 (not 14).
REQ-033 The bench SHALL cover SF=1 and valid gaps: random in_add_v gaps -> each accepted beat yields exactly one equal sign-extended output, and idle cycles change nothing.
